// File: rtl/refresh_req_gen.sv
// rtl/refresh_req_gen.sv - DRAM refresh request generator
// Interval timer feeds a saturating owed-refresh counter drained by a refreq/refack handshake.
module refresh_req_gen #(
    parameter int PRESCALE = 16,
    parameter int RATE_W   = 4,
    parameter int MAXPEND  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RATE_W-1:0] refrate,
    input  logic              refack,
    input  logic              ovclr,
    output logic              refreq,
    output logic [2:0]        pending,
    output logic              overflow,
    output logic              busy
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [2:0]      PEND_MAX = 3'(MAXPEND);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2
    } state_t;

    logic [PS_W-1:0]   prescaler;
    logic [RATE_W-1:0] counter;
    logic              enabled;
    logic              tick;
    logic              expire;

    state_t            state_q;
    state_t            state_d;
    logic              refreq_q;
    logic              refreq_d;
    logic              busy_q;
    logic              busy_d;
    logic              retire;

    logic [2:0]        pending_q;
    logic              overflow_q;
    logic              ovf_set;

    assign enabled = (refrate != '0);
    assign tick    = (prescaler == PS_LAST);
    // counter==0 only before the first enabled edge; that edge loads it without expiring
    assign expire  = enabled && tick && (counter == RATE_W'(1));

    always_ff @(posedge clk) begin
        if (reset || !enabled) begin
            prescaler <= '0;
            counter   <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PS_W'(1);
            if (counter == '0) begin
                counter <= refrate;
            end else if (tick) begin
                counter <= (counter == RATE_W'(1)) ? refrate : counter - RATE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            refreq_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            refreq_q <= refreq_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        refreq_d = 1'b0;
        busy_d   = 1'b0;
        retire   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q != 3'd0) begin
                    state_d  = REQ;
                    refreq_d = 1'b1;
                end
            end
            REQ: begin
                if (refack) begin
                    state_d = SERVE;
                    busy_d  = 1'b1;
                end else begin
                    refreq_d = 1'b1;
                end
            end
            SERVE: begin
                // a refresh is only retired once the grant has been released
                if (!refack) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ovf_set = expire && !retire && (pending_q == PEND_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            if (expire && !retire && (pending_q != PEND_MAX)) begin
                pending_q <= pending_q + 3'd1;
            end else if (retire && !expire) begin
                pending_q <= pending_q - 3'd1;
            end
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (ovclr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign refreq   = refreq_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_refresh_req_gen.sv
// tb/tb_refresh_req_gen.sv - directed bench for refresh_req_gen
module tb_refresh_req_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] refrate;
    logic       refack;
    logic       ovclr;
    logic       refreq;
    logic [2:0] pending;
    logic       overflow;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int g0    = 0;

    always #5 clk = ~clk;

    refresh_req_gen #(.PRESCALE(16), .RATE_W(4), .MAXPEND(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .refrate  (refrate),
        .refack   (refack),
        .ovclr    (ovclr),
        .refreq   (refreq),
        .pending  (pending),
        .overflow (overflow),
        .busy     (busy)
    );

    typedef struct {
        int         n;
        logic       rst;
        logic [3:0] rate;
        logic       ack;
        logic       clr;
        logic       e_req;
        logic [2:0] e_pend;
        logic       e_ovf;
        logic       e_busy;
    } vec_t;

    vec_t vecs[17];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [2:0] e_pend,
                           input logic e_ovf, input logic e_busy);
        chk($sformatf("%s refreq", tag),   8'(refreq),   8'(e_req));
        chk($sformatf("%s pending", tag),  8'(pending),  8'(e_pend));
        chk($sformatf("%s overflow", tag), 8'(overflow), 8'(e_ovf));
        chk($sformatf("%s busy", tag),     8'(busy),     8'(e_busy));
    endtask

    initial begin
        reset   = 1'b1;
        refrate = 4'd0;
        refack  = 1'b0;
        ovclr   = 1'b0;

        // refrate=2: expiries at first-enabled-edge F+31, +63, +95, +127, +159
        vecs[0]  = '{2,  1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{31, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1,  1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
        vecs[3]  = '{1,  1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
        vecs[4]  = '{30, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
        vecs[5]  = '{1,  1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
        vecs[6]  = '{32, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0};
        vecs[7]  = '{31, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0};
        vecs[8]  = '{1,  1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0};
        vecs[9]  = '{1,  1'b0, 4'd2, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0};
        vecs[10] = '{30, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0};
        vecs[11] = '{1,  1'b0, 4'd2, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0};
        vecs[12] = '{1,  1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0};
        vecs[13] = '{1,  1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1};
        vecs[14] = '{3,  1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1};
        vecs[15] = '{1,  1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[16] = '{3,  1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            reset   = vecs[i].rst;
            refrate = vecs[i].rate;
            refack  = vecs[i].ack;
            ovclr   = vecs[i].clr;
            for (int k = 0; k < vecs[i].n; k++) step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_pend,
                    vecs[i].e_ovf, vecs[i].e_busy);
        end

        // refrate=1 handshakes: expiries at G+15, +31, +47, +63
        refack = 1'b0;
        reset  = 1'b1;
        step();
        reset   = 1'b0;
        refrate = 4'd1;
        g0      = cyc + 1;
        run_to(g0 + 14);
        chk("hs pre-expiry pending", 8'(pending), 8'd0);
        run_to(g0 + 15);
        chk_all("hs expiry", 1'b0, 3'd1, 1'b0, 1'b0);
        run_to(g0 + 16);
        chk_all("hs first req", 1'b1, 3'd1, 1'b0, 1'b0);
        run_to(g0 + 31);
        chk_all("hs second expiry", 1'b1, 3'd2, 1'b0, 1'b0);

        refack = 1'b1;
        run_to(g0 + 32);
        chk_all("hs grant", 1'b0, 3'd2, 1'b0, 1'b1);
        for (int k = 33; k <= 36; k++) begin
            run_to(g0 + k);
            chk($sformatf("hs hold busy g+%0d", k), 8'(busy), 8'd1);
        end
        refack = 1'b0;
        run_to(g0 + 37);
        chk_all("hs retire", 1'b0, 3'd1, 1'b0, 1'b0);
        run_to(g0 + 38);
        chk_all("hs back-to-back req", 1'b1, 3'd1, 1'b0, 1'b0);

        run_to(g0 + 47);
        chk("hs third expiry pending", 8'(pending), 8'd2);
        refack = 1'b1;
        run_to(g0 + 48);
        chk("hs second grant busy", 8'(busy), 8'd1);
        run_to(g0 + 62);
        refack = 1'b0;
        run_to(g0 + 63);
        chk_all("hs retire with expiry", 1'b0, 3'd2, 1'b0, 1'b0);
        run_to(g0 + 64);
        chk("hs req after coincident", 8'(refreq), 8'd1);

        // timer off: pending 2 drains by two handshakes and nothing else accrues
        refrate = 4'd0;
        refack  = 1'b1;
        step();
        chk_all("drain grant1", 1'b0, 3'd2, 1'b0, 1'b1);
        refack = 1'b0;
        step();
        chk_all("drain retire1", 1'b0, 3'd1, 1'b0, 1'b0);
        step();
        chk("drain req2", 8'(refreq), 8'd1);
        refack = 1'b1;
        step();
        chk("drain grant2 busy", 8'(busy), 8'd1);
        refack = 1'b0;
        step();
        chk_all("drain retire2", 1'b0, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step();
            chk($sformatf("drained refreq +%0d", k), 8'(refreq), 8'd0);
        end
        chk_all("drained final", 1'b0, 3'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
